opendap_swd_host: RTL and testbench

// - SWD initiator (probe side). Turns one DP/AP access command into a complete SWD

---
 rtl/opendap_swd_host.sv | 241 ++++++++++++++++++++++++
 tb/tb_opendap_swd_host.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opendap_swd_host.sv
// opendap_swd_host: SWD initiator. Turns one DP/AP access command into a full SWD
// packet (request, turnaround, ACK, data, parity, trailing idle) on swclk/swdio.
// Optional build macro OPENDAP_SWD_HOST_LINE_RESET_EN adds the line-reset command
// (56 ones then 2 driven zeros) selected by cmd_linereset.
module opendap_swd_host #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned TRAIL_IDLE = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_apndp,
   input  logic        cmd_rnw,
   input  logic [1:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic        cmd_linereset,
   output logic        rsp_valid,
   output logic [2:0]  rsp_ack,
   output logic [31:0] rsp_rdata,
   output logic        rsp_perr,
   output logic        swclk_out,
   output logic        swdo,
   output logic        swdo_en,
   input  logic        swdi
);

   localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TrailW = (TRAIL_IDLE > 0) ? $clog2(TRAIL_IDLE + 1) : 1;
   localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
   localparam logic [TrailW-1:0] TrailLast = TrailW'((TRAIL_IDLE > 0) ? TRAIL_IDLE - 1 : 0);
   localparam logic [2:0]        AckOk     = 3'b001;

   typedef enum logic [3:0] {
      StIdle,
      StReq,
      StTrn1,
      StAck,
      StRdata,
      StRpar,
      StTrn2,
      StWdata,
      StWpar,
      StTrail
`ifdef OPENDAP_SWD_HOST_LINE_RESET_EN
      , StLrst
`endif
   } state_e;

   state_e              state_q, state_d;
   logic [5:0]          bit_q, bit_d;
   logic [TrailW-1:0]   trail_q, trail_d;
   logic [DivW-1:0]     div_q, div_d;
   logic                swclk_q, swclk_d;
   logic                swdo_q, swdo_d;
   logic                swdo_en_q, swdo_en_d;
   logic [7:0]          req_q, req_d;
   logic                rnw_q, rnw_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [2:0]          ack_q, ack_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                rpar_q, rpar_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [2:0]          rsp_ack_q, rsp_ack_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_perr_q, rsp_perr_d;

   logic                low_end, high_end, done, ack_ok, rd_ok, is_lrst;
   logic [5:0]          last_idx;
   state_e              nxt, after_data;

`ifndef OPENDAP_SWD_HOST_LINE_RESET_EN
   logic unused_linereset;
   assign unused_linereset = cmd_linereset;
`endif

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_q       <= '0;
         trail_q     <= '0;
         div_q       <= '0;
         swclk_q     <= 1'b0;
         swdo_q      <= 1'b0;
         swdo_en_q   <= 1'b0;
         req_q       <= '0;
         rnw_q       <= 1'b0;
         wdata_q     <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
         rpar_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_ack_q   <= '0;
         rsp_rdata_q <= '0;
         rsp_perr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         trail_q     <= trail_d;
         div_q       <= div_d;
         swclk_q     <= swclk_d;
         swdo_q      <= swdo_d;
         swdo_en_q   <= swdo_en_d;
         req_q       <= req_d;
         rnw_q       <= rnw_d;
         wdata_q     <= wdata_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         rpar_q      <= rpar_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ack_q   <= rsp_ack_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_perr_q  <= rsp_perr_d;
      end
   end

   // Next-state: clock divider, bit sequencing, swdi sampling and response capture
   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      trail_d     = trail_q;
      div_d       = div_q;
      swclk_d     = swclk_q;
      swdo_d      = swdo_q;
      swdo_en_d   = swdo_en_q;
      req_d       = req_q;
      rnw_d       = rnw_q;
      wdata_d     = wdata_q;
      ack_d       = ack_q;
      rdata_d     = rdata_q;
      rpar_d      = rpar_q;
      rsp_valid_d = 1'b0;
      rsp_ack_d   = rsp_ack_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_perr_d  = rsp_perr_q;
      low_end     = (state_q != StIdle) && !swclk_q && (div_q == DivLast);
      high_end    = (state_q != StIdle) && swclk_q && (div_q == DivLast);
      ack_ok      = (ack_q == AckOk);
      rd_ok       = ack_ok && rnw_q;
      after_data  = (TRAIL_IDLE > 0) ? StTrail : StIdle;
      done        = 1'b0;
      last_idx    = '0;
      nxt         = StIdle;
`ifdef OPENDAP_SWD_HOST_LINE_RESET_EN
      is_lrst     = (state_q == StLrst);
`else
      is_lrst     = 1'b0;
`endif

      if (state_q == StIdle) begin
         if (cmd_valid) begin
            // Start bit goes out on the transfer clk; the rest of the request is latched
            state_d   = StReq;
            bit_d     = '0;
            div_d     = '0;
            swclk_d   = 1'b0;
            swdo_d    = 1'b1;
            swdo_en_d = 1'b1;
            req_d     = {1'b1, 1'b0, ^{cmd_apndp, cmd_rnw, cmd_addr}, cmd_addr[1],
                         cmd_addr[0], cmd_rnw, cmd_apndp, 1'b1};
            rnw_d     = cmd_rnw;
            wdata_d   = cmd_wdata;
`ifdef OPENDAP_SWD_HOST_LINE_RESET_EN
            if (cmd_linereset) state_d = StLrst;
`endif
         end
      end else begin
         div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
         if (low_end) begin
            swclk_d = 1'b1;
            unique case (state_q)
               StAck:   ack_d[bit_q[1:0]] = swdi;
               StRdata: rdata_d[bit_q[4:0]] = swdi;
               StRpar:  rpar_d = swdi;
               default: ;
            endcase
         end
         if (high_end) begin
            swclk_d = 1'b0;
            unique case (state_q)
               StReq:   begin last_idx = 6'd7;  nxt = StTrn1; end
               StTrn1:  begin last_idx = 6'd0;  nxt = StAck; end
               StAck:   begin last_idx = 6'd2;  nxt = rd_ok ? StRdata : StTrn2; end
               StRdata: begin last_idx = 6'd31; nxt = StRpar; end
               StRpar:  begin last_idx = 6'd0;  nxt = StTrn2; end
               StTrn2:  begin last_idx = 6'd0;  nxt = (ack_ok && !rnw_q) ? StWdata : after_data; end
               StWdata: begin last_idx = 6'd31; nxt = StWpar; end
               StWpar:  begin last_idx = 6'd0;  nxt = after_data; end
`ifdef OPENDAP_SWD_HOST_LINE_RESET_EN
               StLrst:  begin last_idx = 6'd57; nxt = StIdle; end
`endif
               default: begin last_idx = 6'd0;  nxt = StIdle; end
            endcase
            if (state_q == StTrail) begin
               done    = (trail_q == TrailLast);
               trail_d = done ? '0 : trail_q + TrailW'(1);
            end else begin
               done  = (bit_q == last_idx);
               bit_d = done ? '0 : bit_q + 6'd1;
            end
            if (done) begin
               state_d = nxt;
               bit_d   = '0;
               trail_d = '0;
            end

            // Drive the next bit at the start of its low phase
            swdo_d    = 1'b0;
            swdo_en_d = 1'b0;
            unique case (state_d)
               StReq:   begin swdo_en_d = 1'b1; swdo_d = req_q[bit_d[2:0]]; end
               StWdata: begin swdo_en_d = 1'b1; swdo_d = wdata_q[bit_d[4:0]]; end
               StWpar:  begin swdo_en_d = 1'b1; swdo_d = ^wdata_q; end
               StTrail: swdo_en_d = 1'b1;
`ifdef OPENDAP_SWD_HOST_LINE_RESET_EN
               StLrst:  begin swdo_en_d = 1'b1; swdo_d = (bit_d < 6'd56); end
`endif
               default: ;
            endcase

            if (state_d == StIdle) begin
               rsp_valid_d = 1'b1;
               rsp_ack_d   = is_lrst ? 3'b000 : ack_q;
               rsp_rdata_d = (rd_ok && !is_lrst) ? rdata_q : 32'h0;
               rsp_perr_d  = rd_ok && !is_lrst && ((^rdata_q) != rpar_q);
            end
         end
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = rsp_valid_q;
   assign rsp_ack   = rsp_ack_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_perr  = rsp_perr_q;
   assign swclk_out = swclk_q;
   assign swdo      = swdo_q;
   assign swdo_en   = swdo_en_q;

endmodule

// File: tb/tb_opendap_swd_host.sv
// Bench for opendap_swd_host: a behavioural SW-DP target answers each packet from a
// per-bit swdi schedule, and the host's wire bits, timing and response are compared
// against values computed from the SWD packet rules.
module tb_opendap_swd_host;

   localparam int unsigned Div   = 3;
   localparam int unsigned Trail = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_apndp, cmd_rnw, cmd_linereset;
   logic [1:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_perr;
   logic [2:0]  rsp_ack;
   logic [31:0] rsp_rdata;
   logic        swclk_out, swdo, swdo_en, swdi;

   logic        c1_valid, c1_ready, r1_valid, r1_perr, sclk1, sdo1, sen1;
   logic [2:0]  r1_ack;
   logic [31:0] r1_rdata;

   int          tests = 0;
   int          fails = 0;
   int          edge_cnt = 0;
   int          rv_cnt = 0;
   int          rv1_cnt = 0;
   logic [63:0] got_en, got_do, sched;
   logic [31:0] ctrl_model;

   always #5 clk = ~clk;

   opendap_swd_host #(.CLK_DIV(Div), .TRAIL_IDLE(Trail)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_apndp(cmd_apndp), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_linereset(cmd_linereset), .rsp_valid(rsp_valid),
      .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
      .swclk_out(swclk_out), .swdo(swdo), .swdo_en(swdo_en), .swdi(swdi)
   );

   // Fast divider, no trailing idle, no target (swdi pulled high)
   opendap_swd_host #(.CLK_DIV(1), .TRAIL_IDLE(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
      .cmd_apndp(1'b0), .cmd_rnw(1'b1), .cmd_addr(2'b00), .cmd_wdata(32'h0),
      .cmd_linereset(1'b0), .rsp_valid(r1_valid), .rsp_ack(r1_ack),
      .rsp_rdata(r1_rdata), .rsp_perr(r1_perr), .swclk_out(sclk1), .swdo(sdo1),
      .swdo_en(sen1), .swdi(1'b1)
   );

   // Target: capture host bit on swclk rise, then present its bit for the next slot
   always @(posedge swclk_out) begin
      if (edge_cnt < 64) begin
         got_en[edge_cnt] = swdo_en;
         got_do[edge_cnt] = swdo;
      end
      edge_cnt = edge_cnt + 1;
      #1;
      swdi = (edge_cnt < 64) ? sched[edge_cnt] : 1'b1;
   end

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) rv_cnt = rv_cnt + 1;
      if (r1_valid === 1'b1) rv1_cnt = rv1_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // DP register model: DPIDR at A=0, CTRL/STAT at A=1 with power-up acks looped back
   function automatic logic [31:0] dp_read(input logic [1:0] a);
      if (a == 2'd0) return 32'hdeadbeef;
      if (a == 2'd1) return ctrl_model | ((ctrl_model & 32'h5000_0000) << 1);
      return 32'h0;
   endfunction

   task automatic xfer(input string tag, input bit apndp, input bit rnw, input bit [1:0] addr,
                       input bit [31:0] wdata, input bit [2:0] ack, input bit [31:0] rdata,
                       input bit badpar, input bit poke, input bit lr);
      bit          exp_lr, ok;
      int          n, cyc;
      logic [63:0] een, edo;
      logic [7:0]  reqb;
`ifdef OPENDAP_SWD_HOST_LINE_RESET_EN
      exp_lr = lr;
`else
      exp_lr = 1'b0;
`endif
      ok    = (ack == 3'b001);
      sched = '1;
      if (!exp_lr) begin
         for (int i = 0; i < 3; i++) sched[9 + i] = ack[i];
         if (ok && rnw) begin
            for (int i = 0; i < 32; i++) sched[12 + i] = rdata[i];
            sched[44] = (^rdata) ^ badpar;
         end
      end
      // Expected host wire: enable and driven value per bit slot
      een  = '0;
      edo  = '0;
      reqb = 8'(1 + (apndp << 1) + (rnw << 2) + (addr[0] << 3) + (addr[1] << 4)
                + ((apndp ^ rnw ^ addr[0] ^ addr[1]) << 5) + (1 << 7));
      if (exp_lr) begin
         for (int i = 0; i < 58; i++) begin
            een[i] = 1'b1;
            edo[i] = (i < 56);
         end
         n = 58;
      end else begin
         for (int i = 0; i < 8; i++) begin
            een[i] = 1'b1;
            edo[i] = reqb[i];
         end
         if (ok && rnw) n = 46;
         else if (ok) begin
            for (int i = 0; i < 32; i++) begin
               een[13 + i] = 1'b1;
               edo[13 + i] = wdata[i];
            end
            een[45] = 1'b1;
            edo[45] = ^wdata;
            n = 46;
         end else n = 13;
         for (int i = 0; i < int'(Trail); i++) een[n + i] = 1'b1;
         n = n + int'(Trail);
      end

      edge_cnt = 0;
      got_en   = '0;
      got_do   = '0;
      swdi     = sched[0];
      @(negedge clk);
      chk({tag, "/ready"}, cmd_ready, 1'b1);
      cmd_valid     = 1'b1;
      cmd_apndp     = apndp;
      cmd_rnw       = rnw;
      cmd_addr      = addr;
      cmd_wdata     = wdata;
      cmd_linereset = lr;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (poke && cyc == 4) begin
            cmd_valid     = 1'b1;
            cmd_apndp     = ~apndp;
            cmd_rnw       = ~rnw;
            cmd_addr      = ~addr;
            cmd_wdata     = ~wdata;
            cmd_linereset = ~lr;
         end
         if (poke && cyc == 5) cmd_valid = 1'b0;
      end
      chk({tag, "/clks"}, cyc, n * 2 * int'(Div));
      chk({tag, "/bits"}, edge_cnt, n);
      chk({tag, "/ack"}, rsp_ack, exp_lr ? 3'b000 : ack);
      chk({tag, "/rdata"}, rsp_rdata, (!exp_lr && ok && rnw) ? rdata : 32'h0);
      chk({tag, "/perr"}, rsp_perr, !exp_lr && ok && rnw && badpar);
      chk({tag, "/wire_en"}, got_en, een);
      chk({tag, "/wire_do"}, got_do & een, edo);
      if (!exp_lr) chk({tag, "/reqbyte"}, got_do[7:0], reqb);
      chk({tag, "/ready_done"}, cmd_ready, 1'b1);
      @(negedge clk);
      chk({tag, "/pulse"}, rsp_valid, 1'b0);
      chk({tag, "/clk_idle"}, swclk_out, 1'b0);
   endtask

   initial begin
      int          cyc, rv0;
      bit          apndp, rnw, badpar;
      bit [1:0]    addr;
      bit [2:0]    ack;
      bit [31:0]   rd;
      rst_n         = 1'b0;
      cmd_valid     = 1'b0;
      cmd_apndp     = 1'b0;
      cmd_rnw       = 1'b0;
      cmd_addr      = 2'b00;
      cmd_wdata     = 32'h0;
      cmd_linereset = 1'b0;
      c1_valid      = 1'b0;
      swdi          = 1'b1;
      sched         = '1;
      ctrl_model    = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst/ready", cmd_ready, 1'b1);
      chk("rst/valid", rsp_valid, 1'b0);
      chk("rst/ack", rsp_ack, 3'b000);
      chk("rst/rdata", rsp_rdata, 32'h0);
      chk("rst/perr", rsp_perr, 1'b0);
      chk("rst/swclk", swclk_out, 1'b0);
      chk("rst/swdo", swdo, 1'b0);
      chk("rst/swdo_en", swdo_en, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef OPENDAP_SWD_HOST_LINE_RESET_EN
      xfer("lrst", 1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 32'h0, 1'b0, 1'b0, 1'b1);
`endif
      xfer("dpidr", 1'b0, 1'b1, 2'd0, 32'h0, 3'b001, dp_read(2'd0), 1'b0, 1'b0, 1'b0);
      chk("dpidr/a5", got_do[7:0], 8'hA5);
      xfer("ctrl_wr", 1'b0, 1'b0, 2'd1, 32'h5000_0000, 3'b001, 32'h0, 1'b0, 1'b0, 1'b0);
      ctrl_model = 32'h5000_0000;
      xfer("ctrl_rd", 1'b0, 1'b1, 2'd1, 32'h0, 3'b001, dp_read(2'd1), 1'b0, 1'b0, 1'b0);
      chk("ctrl_rd/pwr", rsp_rdata[31:28], 4'hf);
      xfer("badpar", 1'b1, 1'b1, 2'd3, 32'h0, 3'b001, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      xfer("wait", 1'b1, 1'b1, 2'd2, 32'h0, 3'b010, 32'hffff_ffff, 1'b0, 1'b0, 1'b0);
      xfer("notgt", 1'b0, 1'b1, 2'd0, 32'h0, 3'b111, 32'h0, 1'b0, 1'b0, 1'b0);
`ifndef OPENDAP_SWD_HOST_LINE_RESET_EN
      xfer("lr_ign", 1'b0, 1'b1, 2'd0, 32'h0, 3'b001, 32'hcafe_f00d, 1'b0, 1'b0, 1'b1);
`endif

      for (int k = 0; k < 12; k++) begin
         apndp  = 1'($urandom_range(0, 1));
         rnw    = 1'($urandom_range(0, 1));
         addr   = 2'($urandom_range(0, 3));
         rd     = $urandom;
         badpar = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 6))
            3:       ack = 3'b010;
            4:       ack = 3'b100;
            5:       ack = 3'b111;
            6:       ack = 3'b011;
            default: ack = 3'b001;
         endcase
         xfer($sformatf("rnd%0d", k), apndp, rnw, addr, $urandom, ack, rd, badpar,
              1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset during read data: packet abandoned, no response
      sched = '1;
      for (int i = 0; i < 3; i++) sched[9 + i] = (i == 0);
      edge_cnt = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rnw   = 1'b1;
      cmd_apndp = 1'b0;
      cmd_addr  = 2'd0;
      cmd_linereset = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 0;
      while (edge_cnt < 20 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("mrst/reach_rdata", edge_cnt, 20);
      rv0   = rv_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst/swclk", swclk_out, 1'b0);
      chk("mrst/swdo_en", swdo_en, 1'b0);
      chk("mrst/ready", cmd_ready, 1'b1);
      chk("mrst/valid", rsp_valid, 1'b0);
      repeat (200) @(negedge clk);
      chk("mrst/no_rsp", rv_cnt, rv0);
      chk("mrst/idle_clk", swclk_out, 1'b0);

      // CLK_DIV=1, TRAIL_IDLE=0, no target
      rv0 = rv1_cnt;
      @(negedge clk);
      chk("nt1/ready", c1_ready, 1'b1);
      c1_valid = 1'b1;
      @(negedge clk);
      c1_valid = 1'b0;
      cyc = 0;
      while (r1_valid !== 1'b1 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("nt1/clks", cyc, 13 * 2);
      chk("nt1/ack", r1_ack, 3'b111);
      chk("nt1/rdata", r1_rdata, 32'h0);
      chk("nt1/perr", r1_perr, 1'b0);
      repeat (40) @(negedge clk);
      chk("nt1/once", rv1_cnt - rv0, 1);
      chk("nt1/en_idle", sen1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
